// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte queue and launch controller feeding a UART transmitter
//
// Purpose:
//    Accepts words from a producer over a valid/ready write port, stores them
//    in a circular FIFO, and launches them one at a time into the transmitter
//    using a one-cycle uart_tx_en pulse. The pulse is paced by uart_tx_busy.
//
// Ports:
//    clk, resetn    - system clock; asynchronous active-low reset
//    clear          - synchronous flush of queued, not-yet-issued words
//    wr_valid       - producer handshake: a word is present on wr_data
//    wr_ready       - producer handshake: a word can be taken this cycle
//    wr_data        - word to enqueue
//    uart_tx_en     - one-cycle launch pulse to the transmitter
//    uart_tx_data   - launched word; held until the next launch
//    uart_tx_busy   - transmitter busy; rises the cycle after it takes uart_tx_en
//    fifo_count     - stored entries, 0..DEPTH
//    fifo_empty     - fifo_count == 0
//    fifo_full      - fifo_count == DEPTH

module uart_tx_fifo #(
   parameter int PAYLOAD_BITS = 8,
   parameter int DEPTH        = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      clear,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [PAYLOAD_BITS-1:0]   wr_data,
   output logic                      uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]   uart_tx_data,
   input  logic                      uart_tx_busy,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      fifo_empty,
   output logic                      fifo_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRE  = 2'd1,
      ST_ACK   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];

   state_t                  state_q,    state_d;
   logic [AW-1:0]           wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]           count_q,    count_d;
   logic                    empty_q,    empty_d;
   logic                    full_q,     full_d;
   logic                    wr_ready_q, wr_ready_d;
   logic                    tx_en_q,    tx_en_d;
   logic [PAYLOAD_BITS-1:0] tx_data_q,  tx_data_d;

   logic                    do_write;
   logic                    do_pop;

   // Handshakes use only registered status, so a word written into an empty
   // queue is not visible to the pop logic until the following edge.
   assign do_write = wr_valid && wr_ready_q && !clear;
   assign do_pop   = (state_q == ST_IDLE) && !empty_q && !uart_tx_busy && !clear;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      state_d   = state_q;
      tx_en_d   = 1'b0;
      tx_data_d = tx_data_q;

      if (do_write) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (clear) begin
         // Flush: everything between the pointers is discarded. A word already
         // copied into tx_data_q is unaffected.
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_write, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (do_pop) begin
               state_d   = ST_FIRE;
               tx_en_d   = 1'b1;
               tx_data_d = mem_q[rd_ptr_q];
            end
         end
         ST_FIRE: begin
            state_d = ST_ACK;
         end
         ST_ACK: begin
            if (uart_tx_busy) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!uart_tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags reflect the post-edge count so they are valid as soon as
      // they leave the flops.
      wr_ready_d = (count_d != DEPTH_C);
      empty_d    = (count_d == '0);
      full_d     = (count_d == DEPTH_C);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         wr_ready_q <= 1'b0;
         tx_en_q    <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         wr_ready_q <= wr_ready_d;
         tx_en_q    <= tx_en_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Storage array carries no reset; occupancy is tracked by the pointers and
   // count, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign wr_ready     = wr_ready_q;
   assign uart_tx_en   = tx_en_q;
   assign uart_tx_data = tx_data_q;
   assign fifo_count   = count_q;
   assign fifo_empty   = empty_q;
   assign fifo_full    = full_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

   localparam int PB    = 8;
   localparam int DEPTH = 16;
   localparam int FRAME = 6;

   logic          clk = 1'b0;
   logic          resetn;
   logic          clear;
   logic          wr_valid;
   logic          wr_ready;
   logic [PB-1:0] wr_data;
   logic          uart_tx_en;
   logic [PB-1:0] uart_tx_data;
   logic          uart_tx_busy;
   logic [4:0]    fifo_count;
   logic          fifo_empty;
   logic          fifo_full;

   logic          force_busy = 1'b0;
   logic          model_busy = 1'b0;
   int            tx_cnt     = 0;
   logic          prev_en    = 1'b0;
   int            n_launch   = 0;
   int            n_double   = 0;
   int            n_checks   = 0;
   int            n_errors   = 0;
   int            base;
   logic [PB-1:0] launched [$];
   logic [PB-1:0] expq     [$];

   always #5 clk = ~clk;

   assign uart_tx_busy = model_busy | force_busy;

   uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .clear        (clear),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full)
   );

   // Transmitter stand-in: samples uart_tx_en, raises busy the next cycle and
   // holds it for FRAME cycles; records every launched word.
   always @(posedge clk) begin
      prev_en <= uart_tx_en;
      if (uart_tx_en && prev_en) n_double <= n_double + 1;
      if (tx_cnt > 0) begin
         tx_cnt <= tx_cnt - 1;
         if (tx_cnt == 1) model_busy <= 1'b0;
      end
      if (uart_tx_en) begin
         model_busy <= 1'b1;
         tx_cnt     <= FRAME;
         launched.push_back(uart_tx_data);
         n_launch   <= n_launch + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [PB-1:0] d);
      logic acc;
      logic done;
      done     = 1'b0;
      wr_valid = 1'b1;
      wr_data  = d;
      for (int t = 0; t < 5000 && !done; t++) begin
         acc = wr_ready && !clear;
         @(posedge clk);
         @(negedge clk);
         done = acc;
      end
      wr_valid = 1'b0;
      if (!done) check("push_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_idle();
      int quiet;
      quiet = 0;
      for (int t = 0; t < 3000 && quiet < 4; t++) begin
         @(negedge clk);
         if (fifo_empty && !uart_tx_busy && !uart_tx_en) quiet++;
         else quiet = 0;
      end
      if (quiet < 4) check("idle_timeout", 32'(0), 32'(1));
   endtask

   task automatic cmp_sb(input string tag);
      check({tag, "_len"}, 32'(launched.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < launched.size(); i++) begin
         check(tag, 32'(launched[i]), 32'(expq[i]));
      end
      launched.delete();
      expq.delete();
   endtask

   initial begin
      resetn   = 1'b0;
      clear    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;

      repeat (3) @(negedge clk);
      check("rst_en",       32'(uart_tx_en),   32'(0));
      check("rst_data",     32'(uart_tx_data), 32'(0));
      check("rst_wr_ready", 32'(wr_ready),     32'(0));
      check("rst_count",    32'(fifo_count),   32'(0));
      check("rst_empty",    32'(fifo_empty),   32'(1));
      check("rst_full",     32'(fifo_full),    32'(0));

      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_wr_ready", 32'(wr_ready), 32'(1));

      // Single word: accepted at E0, launched E1..E2.
      wr_valid = 1'b1;
      wr_data  = 8'h55;
      @(negedge clk);
      wr_valid = 1'b0;
      check("t1_count_e0", 32'(fifo_count), 32'(1));
      check("t1_en_e0",    32'(uart_tx_en), 32'(0));
      check("t1_empty_e0", 32'(fifo_empty), 32'(0));
      @(negedge clk);
      check("t1_en_e1",    32'(uart_tx_en),   32'(1));
      check("t1_data_e1",  32'(uart_tx_data), 32'(8'h55));
      check("t1_count_e1", 32'(fifo_count),   32'(0));
      @(negedge clk);
      check("t1_en_e2",    32'(uart_tx_en),   32'(0));
      wait_idle();
      expq.push_back(8'h55);
      cmp_sb("t1_order");

      // Fill to full while the transmitter is held busy, then a 17th word.
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         expq.push_back(8'(i));
      end
      check("t2_count_full", 32'(fifo_count), 32'(16));
      check("t2_full",       32'(fifo_full),  32'(1));
      check("t2_wr_ready",   32'(wr_ready),   32'(0));
      wr_valid = 1'b1;
      wr_data  = 8'h10;
      repeat (3) @(negedge clk);
      check("t2_held_count", 32'(fifo_count), 32'(16));
      force_busy = 1'b0;
      @(negedge clk);
      check("t2_pop_en",       32'(uart_tx_en), 32'(1));
      check("t2_pop_count",    32'(fifo_count), 32'(15));
      check("t2_pop_wr_ready", 32'(wr_ready),   32'(1));
      check("t2_pop_full",     32'(fifo_full),  32'(0));
      @(negedge clk);
      wr_valid = 1'b0;
      check("t2_17th_count",    32'(fifo_count), 32'(16));
      check("t2_17th_wr_ready", 32'(wr_ready),   32'(0));
      expq.push_back(8'h10);
      wait_idle();
      cmp_sb("t2_order");

      // 20 words while the transmitter drains concurrently (pointer wrap).
      for (int i = 0; i < 20; i++) begin
         push(8'(8'h30 + i));
         expq.push_back(8'(8'h30 + i));
      end
      wait_idle();
      cmp_sb("t3_order");

      // Clear while the first of five words is on the line.
      base = n_launch;
      for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
      check("t4_count_pre", 32'(fifo_count), 32'(4));
      clear    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hAA;
      @(negedge clk);
      clear    = 1'b0;
      wr_valid = 1'b0;
      check("t4_count_clr", 32'(fifo_count),   32'(0));
      check("t4_empty_clr", 32'(fifo_empty),   32'(1));
      check("t4_data_kept", 32'(uart_tx_data), 32'(8'hC0));
      wait_idle();
      check("t4_launches", 32'(n_launch - base), 32'(1));
      expq.push_back(8'hC0);
      cmp_sb("t4_order");

      // External busy blocks issue; release resumes one cycle later.
      force_busy = 1'b1;
      base = n_launch;
      for (int i = 0; i < 3; i++) begin
         push(8'(8'hD0 + i));
         expq.push_back(8'(8'hD0 + i));
      end
      repeat (20) @(negedge clk);
      check("t5_no_launch", 32'(n_launch - base), 32'(0));
      check("t5_count",     32'(fifo_count),      32'(3));
      force_busy = 1'b0;
      @(negedge clk);
      check("t5_resume_en",   32'(uart_tx_en),   32'(1));
      check("t5_resume_data", 32'(uart_tx_data), 32'(8'hD0));
      wait_idle();
      cmp_sb("t5_order");

      // Asynchronous reset during DRAIN with four words queued.
      for (int i = 0; i < 5; i++) push(8'(8'hE0 + i));
      check("t6_count_pre", 32'(fifo_count),   32'(4));
      check("t6_busy_pre",  32'(uart_tx_busy), 32'(1));
      base = n_launch;
      #2 resetn = 1'b0;
      #1;
      check("t6_async_en",       32'(uart_tx_en),   32'(0));
      check("t6_async_count",    32'(fifo_count),   32'(0));
      check("t6_async_empty",    32'(fifo_empty),   32'(1));
      check("t6_async_full",     32'(fifo_full),    32'(0));
      check("t6_async_wr_ready", 32'(wr_ready),     32'(0));
      check("t6_async_data",     32'(uart_tx_data), 32'(0));
      @(negedge clk);
      resetn = 1'b1;
      repeat (60) @(negedge clk);
      check("t6_no_stale", 32'(n_launch - base), 32'(0));
      check("t6_empty",    32'(fifo_empty),      32'(1));
      expq.push_back(8'hE0);
      cmp_sb("t6_order");

      check("en_single_cycle", 32'(n_double), 32'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
